// File: rtl/write_back_queue_if.sv
// write_back_queue_if: request, commit, register-file and bypass signals of the write-back queue
interface write_back_queue_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4
);
  logic              in_valid, in_ready, in_wen, in_jal, in_ld;
  logic [DATA_W-1:0] in_npc, in_ext, in_mem;
  logic [REG_W-1:0]  in_wreg;
  logic              commit_en, flush;
  logic              rf_WEN;
  logic [REG_W-1:0]  rf_wsel;
  logic [DATA_W-1:0] rf_wdat;
  logic [REG_W-1:0]  byp_rsel;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_dat;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output in_valid, in_wen, in_jal, in_ld, in_npc, in_ext, in_mem, in_wreg, commit_en, flush, byp_rsel,
    input  in_ready, rf_WEN, rf_wsel, rf_wdat, byp_hit, byp_dat, count
  );
  modport slave (
    input  in_valid, in_wen, in_jal, in_ld, in_npc, in_ext, in_mem, in_wreg, commit_en, flush, byp_rsel,
    output in_ready, rf_WEN, rf_wsel, rf_wdat, byp_hit, byp_dat, count
  );
endinterface

// File: rtl/write_back_queue.sv
// write_back_queue: FIFO of pending register writes drained on commit, with youngest-match bypass
module write_back_queue #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4
) (
  input logic CLK,
  input logic RST,
  write_back_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [REG_W-1:0]  wsel_q [DEPTH];
  logic [DATA_W-1:0] wdat_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]       count_q, count_d;
  logic              drain, alloc, hit;
  logic [DATA_W-1:0] sel, dat;
  always_comb begin
    bus.in_ready = (count_q != (PW+1)'(DEPTH)) || bus.commit_en;
    drain = (count_q != '0) && bus.commit_en && !RST;
    alloc = bus.in_valid && bus.in_ready && bus.in_wen && (bus.in_wreg != '0) && !bus.flush;
    sel = bus.in_jal ? bus.in_npc : bus.in_ld ? bus.in_ext : bus.in_mem;
    rd_d = bus.flush ? '0 : rd_q + PW'(drain);
    wr_d = bus.flush ? '0 : wr_q + PW'(alloc);
    count_d = bus.flush ? '0 : count_q + (PW+1)'(alloc) - (PW+1)'(drain);
    bus.rf_WEN = drain;
    bus.rf_wsel = drain ? wsel_q[rd_q] : '0;
    bus.rf_wdat = drain ? wdat_q[rd_q] : '0;
    bus.count = count_q;
  end
  // scan oldest to youngest so the last match left standing is the youngest
  always_comb begin
    hit = 1'b0;
    dat = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < count_q && wsel_q[rd_q + PW'(i)] == bus.byp_rsel && bus.byp_rsel != '0) begin
        hit = 1'b1;
        dat = wdat_q[rd_q + PW'(i)];
      end
    bus.byp_hit = hit;
    bus.byp_dat = dat;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  always_ff @(posedge CLK)
    if (alloc) begin
      wsel_q[wr_q] <= bus.in_wreg;
      wdat_q[wr_q] <= sel;
    end
endmodule
